mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 16, is the maximum consecutive grants one port may hold under lock before it is forced to release.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 p0_req / p1_req  input  1  port 0 (fetch) / port 1 (load-store) request valid.
REQ-005 p0_addr / p1_addr  input  32  byte-independent word address; only bits [`MEM_ADDR_WIDTH-1:0] are meaningful downstream.
REQ-006 p0_wdata / p1_wdata  input  `MEM_DATA_WIDTH  write data.
REQ-007 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-008 p0_lock / p1_lock  input  1  request to keep the grant on the next cycle (atomic sequence).
REQ-009 p0_gnt / p1_gnt  output  1  request accepted this cycle.
REQ-010 p0_rvalid / p1_rvalid  output  1  read data valid on rdata_out this cycle.
REQ-011 rdata_out  output  32  read data returned to the owning port.
REQ-012 mem_addr  output  32, mem_wdata  output  `MEM_DATA_WIDTH, mem_rw  output  1  memory command port (combinational from grant).
REQ-013 mem_rdata  input  32  memory read data, valid one cycle after a read command.

Function
REQ-014 At most one of p0_gnt, p1_gnt is high in any cycle; a grant only goes to a port whose req is high.
REQ-015 Granted port's addr and wdata drive mem_addr and mem_wdata in the same cycle; mem_rw = granted port's we; with no grant mem_rw = 0 and mem_addr/mem_wdata = 0.
REQ-016 Arbitration states: IDLE, LOCK0, LOCK1.
REQ-017 IDLE, one requester: that port granted; both requesting: port not granted most recently (last_gnt) wins.
REQ-018 last_gnt updates to the granted port on every grant; it is unchanged on cycles without a grant.
REQ-019 IDLE -> LOCKn when port n is granted with pn_lock = 1; lock counter loads 1.
REQ-020 LOCKn: port n has absolute priority; if pn_req is high it is granted and the lock counter increments.
REQ-021 LOCKn -> IDLE when pn_lock is 0 on a granted cycle, when pn_req is low, or when the lock counter reaches LOCK_MAX; in the last case the other port, if requesting, is granted on the next cycle regardless of lock.
REQ-022 While LOCKn is held with pn_req low, the exit cycle grants nothing; arbitration resumes next cycle.
REQ-023 Read latency is exactly one cycle: a read granted in cycle N produces pn_rvalid = 1 and rdata_out = mem_rdata in cycle N+1 for the same port n; writes produce no rvalid.
REQ-024 Response routing uses a registered (valid, port) tag captured at grant; back-to-back reads from alternating ports return each response to the correct port.
REQ-025 Requesters cannot stall responses; rvalid is a single-cycle pulse.
REQ-026 rdata_out = 0 whenever neither rvalid is high.
REQ-027 Lock counter width is clog2(LOCK_MAX+1); it never wraps and saturates at LOCK_MAX until the exit transition.

Reset
REQ-028 Reset asserted: state = IDLE, last_gnt = port 1 (so port 0 wins the first tie), lock counter = 0, response tag invalid; all grants, rvalids, mem_rw, mem_addr, mem_wdata, rdata_out = 0 immediately, without waiting for clk.
REQ-029 A read granted in the cycle reset asserts produces no rvalid after reset deasserts.
REQ-030 First rising edge after reset deassertion arbitrates normally.

Verification
REQ-031 Reset, then p0_req=p1_req=1 reads for 4 cycles -> grants P0,P1,P0,P1; each rvalid one cycle after its grant on the matching port.
REQ-032 P1 write addr 0x10 data 0xA5A5A5A5, then P0 read addr 0x10 -> mem_rw=1 on write cycle; p0_rvalid next cycle after read with rdata_out=0xA5A5A5A5.
REQ-033 P0 lock=1 and req=1 continuously, P1 req=1, LOCK_MAX=4 -> P0 granted 4 consecutive cycles, then P1 granted, P0 thereafter.
REQ-034 P1 in LOCK1, drops p1_req while P0 requests -> one cycle with no grant, P0 granted the following cycle.
REQ-035 Assert reset asynchronously mid-cycle during a granted read -> all outputs 0 before next clk edge; no rvalid after deassertion; first tie grants P0.
REQ-036 Random req/we/lock stimulus, 10k cycles -> never two grants, every read gets exactly one rvalid on its own port one cycle later, no rvalid for writes.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (p0) and load-store (p1) share one memory port.
// Alternating priority on ties, optional bounded lock for atomic sequences, 1-cycle read return.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif

module mem_arbiter #(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       p0_req,
    input  logic [31:0]                p0_addr,
    input  logic [`MEM_DATA_WIDTH-1:0] p0_wdata,
    input  logic                       p0_we,
    input  logic                       p0_lock,
    input  logic                       p1_req,
    input  logic [31:0]                p1_addr,
    input  logic [`MEM_DATA_WIDTH-1:0] p1_wdata,
    input  logic                       p1_we,
    input  logic                       p1_lock,
    output logic                       p0_gnt,
    output logic                       p1_gnt,
    output logic                       p0_rvalid,
    output logic                       p1_rvalid,
    output logic [31:0]                rdata_out,
    output logic [31:0]                mem_addr,
    output logic [`MEM_DATA_WIDTH-1:0] mem_wdata,
    output logic                       mem_rw,
    input  logic [31:0]                mem_rdata
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    localparam logic [CntW-1:0] LockMax = CntW'(LOCK_MAX);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLock0 = 2'd1;
    localparam logic [1:0] StLock1 = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_port_q, rsp_port_d;
    logic            gnt0, gnt1;

    assign cnt_inc = (lock_cnt_q == LockMax) ? lock_cnt_q : lock_cnt_q + CntOne;

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            StLock0: begin
                if (p0_req) begin
                    gnt0       = 1'b1;
                    lock_cnt_d = cnt_inc;
                    if (!p0_lock || cnt_inc == LockMax) begin
                        state_d    = StIdle;
                        lock_cnt_d = '0;
                    end
                end else begin
                    // Owner went away: this cycle is spent releasing, nobody is granted.
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end
            end
            StLock1: begin
                if (p1_req) begin
                    gnt1       = 1'b1;
                    lock_cnt_d = cnt_inc;
                    if (!p1_lock || cnt_inc == LockMax) begin
                        state_d    = StIdle;
                        lock_cnt_d = '0;
                    end
                end else begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                if (p0_req && p1_req) begin
                    gnt0 = last_gnt_q;
                    gnt1 = !last_gnt_q;
                end else begin
                    gnt0 = p0_req;
                    gnt1 = p1_req;
                end
                if ((gnt0 && p0_lock) || (gnt1 && p1_lock)) begin
                    if (LOCK_MAX > 1) begin
                        state_d    = gnt0 ? StLock0 : StLock1;
                        lock_cnt_d = CntOne;
                    end
                end
            end
        endcase
    end

    // Grants are masked while reset is held so the memory port goes quiet immediately.
    assign p0_gnt = gnt0 & ~reset;
    assign p1_gnt = gnt1 & ~reset;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (p1_gnt) begin
            last_gnt_d = 1'b1;
        end else if (p0_gnt) begin
            last_gnt_d = 1'b0;
        end
    end

    assign rsp_valid_d = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
    assign rsp_port_d  = p1_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rw    = 1'b0;
        if (p0_gnt) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_rw    = p0_we;
        end else if (p1_gnt) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_rw    = p1_we;
        end
    end

    assign p0_rvalid = rsp_valid_q & ~rsp_port_q;
    assign p1_rvalid = rsp_valid_q & rsp_port_q;
    assign rdata_out = rsp_valid_q ? mem_rdata : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            last_gnt_q  <= 1'b1;
            lock_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: driver predicts grants from a reference model and queues
// expected read responses; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int unsigned LockMax = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [31:0] p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_we = 1'b0, p1_we = 1'b0;
    logic        p0_lock = 1'b0, p1_lock = 1'b0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] rdata_out, mem_addr, mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata = '0;

    mem_arbiter #(.LOCK_MAX(LockMax)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_we     (p0_we),
        .p0_lock   (p0_lock),
        .p1_req    (p1_req),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_we     (p1_we),
        .p1_lock   (p1_lock),
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p0_rvalid (p0_rvalid),
        .p1_rvalid (p1_rvalid),
        .rdata_out (rdata_out),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t sbq[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:31];
    bit          pend_wr = 1'b0, pend_rd = 1'b0;
    logic [31:0] pend_addr = '0, pend_data = '0;

    // Reference arbitration state: who owns a lock (-1 none), how long, who won last.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 1;
    endtask

    task automatic model_step(input bit r0, input bit r1, input bit l0, input bit l1,
                              output int g);
        bit rq[2];
        bit lk[2];
        rq[0] = r0; rq[1] = r1; lk[0] = l0; lk[1] = l1;
        g = -1;
        if (m_owner >= 0) begin
            if (rq[m_owner]) begin
                g = m_owner;
                m_held = m_held + 1;
                if (!lk[g] || m_held >= int'(LockMax)) begin
                    m_owner = -1;
                    m_held  = 0;
                end
            end else begin
                m_owner = -1;
                m_held  = 0;
            end
        end else begin
            if (rq[0] && rq[1]) g = 1 - m_last;
            else if (rq[0])     g = 0;
            else if (rq[1])     g = 1;
            if (g >= 0 && lk[g]) begin
                m_owner = g;
                m_held  = 1;
            end
        end
        if (g >= 0) m_last = g;
    endtask

    // One clock of stimulus; exp_dir is a hard-coded expected grant (-1 none, -2 unchecked).
    task automatic cycle(input bit r0, input bit r1, input bit w0, input bit w1,
                         input bit l0, input bit l1, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                         input int exp_dir);
        int g;
        int dut_g;
        logic [31:0] ea, ed, ca;
        bit erw;
        rsp_t e;
        @(posedge clk);
        #1;
        if (pend_wr) mem[pend_addr[4:0]] = pend_data;
        mem_rdata = pend_rd ? mem[pend_addr[4:0]] : $urandom;
        pend_wr = 1'b0;
        pend_rd = 1'b0;
        p0_req = r0; p1_req = r1; p0_we = w0; p1_we = w1; p0_lock = l0; p1_lock = l1;
        p0_addr = a0; p1_addr = a1; p0_wdata = d0; p1_wdata = d1;
        #3;
        model_step(r0, r1, l0, l1, g);
        dut_g = p0_gnt ? 0 : (p1_gnt ? 1 : -1);
        if (exp_dir != -2) chk("directed_gnt", 32'(dut_g), 32'(exp_dir));
        chk("gnt_p0", 32'(p0_gnt), 32'(g == 0));
        chk("gnt_p1", 32'(p1_gnt), 32'(g == 1));
        ea  = (g == 0) ? a0 : (g == 1) ? a1 : 32'h0;
        ed  = (g == 0) ? d0 : (g == 1) ? d1 : 32'h0;
        erw = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("mem_rw", 32'(mem_rw), 32'(erw));
        if (g >= 0) begin
            pend_addr = ea;
            if (erw) begin
                pend_wr   = 1'b1;
                pend_data = ed;
            end else begin
                pend_rd = 1'b1;
                ca = ea;
                e.port = g;
                e.data = mem[ca[4:0]];
                e.due  = cyc + 1;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ctrl"}, 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_rw}), 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rdata"}, rdata_out, 32'h0);
    endtask

    // Monitor: any rvalid must match the oldest outstanding read, on time and on its port.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset) continue;
            chk("single_rvalid", 32'(p0_rvalid && p1_rvalid), 32'h0);
            if (p0_rvalid || p1_rvalid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                    chk("rsp_port", 32'({p0_rvalid, p1_rvalid}), (e.port == 0) ? 32'h2 : 32'h1);
                    chk("rsp_data", rdata_out, e.data);
                end
            end else begin
                chk("rdata_idle", rdata_out, 32'h0);
                if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    chk("missing_rvalid", 32'(e.due), 32'(-1));
                end
            end
        end
    end

    initial begin
        bit r0, r1, w0, w1, l0, l1;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        #2;
        check_quiet("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Tie with reads alternates, starting at port 0.
        for (int i = 0; i < 4; i++)
            cycle(1, 1, 0, 0, 0, 0, 32'h100 + 32'(i), 32'h200 + 32'(i), 0, 0, i % 2);

        // Write from p1, read it back through p0.
        cycle(0, 1, 0, 1, 0, 0, 0, 32'h10, 0, 32'hA5A5A5A5, 1);
        chk("write_rw", 32'(mem_rw), 32'h1);
        cycle(1, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0);
        idle(1);
        chk("readback_rvalid", 32'(p0_rvalid), 32'h1);
        chk("readback_data", rdata_out, 32'hA5A5A5A5);

        // p1 takes a lock, then drops its request: one dead cycle, then p0.
        idle(2);
        cycle(0, 1, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 32'h5, 0, 0, 0, -1);
        cycle(1, 0, 0, 0, 0, 0, 32'h5, 0, 0, 0, 0);

        // p0 locks continuously: LockMax grants, then p1 once, then p0 again.
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h6, 0, 0, 1);
        for (int i = 0; i < int'(LockMax) + 2; i++)
            cycle(1, 1, 0, 0, 1, 0, 32'h7, 32'h8, 0, 0, (i == int'(LockMax)) ? 1 : 0);

        // Asynchronous reset in the middle of a cycle with a read granted and a response live.
        idle(2);
        cycle(1, 0, 0, 0, 0, 0, 32'h9, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 32'hA, 0, 0, 1);
        chk("pre_reset_rvalid", 32'(p0_rvalid), 32'h1);
        reset = 1'b1;
        #0.5;
        check_quiet("async_reset");
        sbq.delete();
        pend_rd = 1'b0;
        pend_wr = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        cycle(1, 1, 0, 0, 0, 0, 32'hB, 32'hC, 0, 0, 0);

        for (int i = 0; i < 10000; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            w0 = $urandom_range(0, 1) == 1;
            w1 = $urandom_range(0, 1) == 1;
            l0 = $urandom_range(0, 2) == 0;
            l1 = $urandom_range(0, 2) == 0;
            cycle(r0, r1, w0, w1, l0, l1, 32'($urandom_range(0, 31)), 32'($urandom_range(0, 31)),
                  $urandom, $urandom, -2);
        end
        idle(3);
        chk("drained", 32'(sbq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
